button_conditioner: RTL and testbench

Front-end conditioner for the seven player push-buttons. It synchronises each raw pad input to `clk`, debounces it, and emits a clean level, a single-cycle press pulse, and a priority-encoded press code. It sits directly upstream of the quiz game FSMs, whose `btn1`..`btn7` inputs are driven from `btn_level` (or `btn_press`) of this block.

---
 rtl/quiz_pkg.sv | 19 +
 rtl/button_conditioner_debounce_channel.sv | 58 +++++
 rtl/button_conditioner.sv | 55 +++++
 tb/tb_button_conditioner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/quiz_pkg.sv
// Shared constants for the quiz game: button count, clock rate, debounce
// defaults, press-code width and the display value codes used by the consumers.
package quiz_pkg;

  localparam int NUM_BTNS                = 7;
  localparam int CLK_HZ                  = 10_000_000;
  localparam int DEBOUNCE_MS             = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DEBOUNCE_CNT_W_DEFAULT  = 17;
  localparam int PRESS_CODE_W            = 3;

  typedef enum logic [3:0] {
    DISP_CORRECT = 4'd10,
    DISP_ERROR   = 4'd11,
    DISP_BLANK   = 4'd12,
    DISP_QUERY   = 4'd13
  } disp_code_t;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: 2-FF synchroniser, stability counter, debounced level
// and a registered one-cycle pulse on each accepted rising edge.
module debounce_channel
  import quiz_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = quiz_pkg::DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = quiz_pkg::DEBOUNCE_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rise_next
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // A change is accepted on the DEBOUNCE_CYCLES-th consecutive disagreeing edge.
  assign accept    = (s2 != level) && (cnt == CNT_LAST);
  assign rise_next = accept && s2;

  // stage: synchroniser s1 -> s2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // stage: stability counter, level and rise pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= rise_next;
      if (s2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Player push-button front end: per-channel debounce plus a registered
// lowest-index priority encoding of the press pulses.
module button_conditioner #(
  parameter int NUM_BTNS        = quiz_pkg::NUM_BTNS,
  parameter int DEBOUNCE_CYCLES = quiz_pkg::DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = quiz_pkg::DEBOUNCE_CNT_W_DEFAULT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_BTNS-1:0]               btn_raw,
  output logic [NUM_BTNS-1:0]               btn_level,
  output logic [NUM_BTNS-1:0]               btn_press,
  output logic                              any_press,
  output logic [quiz_pkg::PRESS_CODE_W-1:0] press_code
);

  import quiz_pkg::*;

  logic [NUM_BTNS-1:0] rise_next;

  function automatic logic [PRESS_CODE_W-1:0] encode_lowest(input logic [NUM_BTNS-1:0] v);
    logic [PRESS_CODE_W-1:0] code;
    code = '0;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (v[i]) code = PRESS_CODE_W'(i + 1);
    end
    return code;
  endfunction

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .raw       (btn_raw[g]),
      .level     (btn_level[g]),
      .press     (btn_press[g]),
      .rise_next (rise_next[g])
    );
  end

  // stage: encoder registered from the same next-cycle rises as btn_press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_press  <= 1'b0;
      press_code <= '0;
    end else begin
      any_press  <= |rise_next;
      press_code <= encode_lowest(rise_next);
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner with a short debounce.
module tb_button_conditioner;

  localparam int N = 7;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_raw = '1;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic         any_press;
  logic [2:0]   press_code;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  button_conditioner #(.NUM_BTNS(N), .DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .any_press  (any_press),
    .press_code (press_code)
  );

  always #5 clk = ~clk;

  // Reference: the synchronised value is the raw sample from two edges back;
  // level flips once the last D synchronised samples all disagree with it.
  logic [N-1:0] hist[$];
  logic [N-1:0] win[$];
  logic [N-1:0] exp_level = '0;
  logic [N-1:0] exp_press = '0;
  logic         exp_any = 1'b0;
  logic [2:0]   exp_code = '0;

  always @(posedge clk or posedge reset) begin
    logic [N-1:0] s2v;
    logic [N-1:0] old;
    bit           all_diff;
    if (reset) begin
      hist.delete();
      win.delete();
      exp_level = '0;
      exp_press = '0;
    end else begin
      s2v = (hist.size() == 2) ? hist[0] : '0;
      hist.push_back(btn_raw);
      if (hist.size() > 2) void'(hist.pop_front());
      win.push_back(s2v);
      if (win.size() > D) void'(win.pop_front());
      old = exp_level;
      for (int i = 0; i < N; i++) begin
        all_diff = (win.size() == D);
        foreach (win[j]) if (win[j][i] == old[i]) all_diff = 1'b0;
        if (all_diff) exp_level[i] = ~old[i];
      end
      exp_press = exp_level & ~old;
    end
    exp_any  = |exp_press;
    exp_code = 3'd0;
    for (int i = N - 1; i >= 0; i--) if (exp_press[i]) exp_code = 3'(i + 1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_level", 32'(btn_level), 32'(exp_level));
      chk("model_press", 32'(btn_press), 32'(exp_press));
      chk("model_any",   32'(any_press), 32'(exp_any));
      chk("model_code",  32'(press_code), 32'(exp_code));
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // reset with all buttons held
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_level", 32'(btn_level), 32'h0);
    chk("rst_press", 32'(btn_press), 32'h0);
    chk("rst_any",   32'(any_press), 32'h0);
    chk("rst_code",  32'(press_code), 32'h0);
    reset = 1'b0;
    ticks(5);
    chk("rst_level_e5", 32'(btn_level), 32'h0);
    tick();
    chk("rst_level_e6", 32'(btn_level), 32'h7f);
    chk("rst_press_e6", 32'(btn_press), 32'h7f);
    chk("rst_code_e6",  32'(press_code), 32'd1);
    tick();
    chk("rst_press_e7", 32'(btn_press), 32'h0);

    // clean press on btn3
    btn_raw = '0;
    ticks(10);
    btn_raw = 7'h04;
    ticks(5);
    chk("b3_early", 32'(btn_press), 32'h0);
    tick();
    chk("b3_press", 32'(btn_press), 32'h04);
    chk("b3_code",  32'(press_code), 32'd3);
    chk("b3_any",   32'(any_press), 32'd1);
    tick();
    chk("b3_once",  32'(btn_press), 32'h0);
    ticks(10);

    // bouncing btn5
    btn_raw = '0;
    ticks(10);
    for (int k = 0; k < 4; k++) begin
      btn_raw[4] = ~k[0];
      ticks(2);
      chk("b5_bounce", 32'(btn_press), 32'h0);
    end
    btn_raw[4] = 1'b1;
    ticks(5);
    chk("b5_early", 32'(btn_press), 32'h0);
    tick();
    chk("b5_press", 32'(btn_press), 32'h10);
    chk("b5_code",  32'(press_code), 32'd5);

    // simultaneous btn2 and btn6
    btn_raw = '0;
    ticks(10);
    btn_raw = 7'h22;
    ticks(6);
    chk("sim_press", 32'(btn_press), 32'h22);
    chk("sim_code",  32'(press_code), 32'd2);
    chk("sim_any",   32'(any_press), 32'd1);

    // btn7 press, release, re-press
    btn_raw = '0;
    ticks(10);
    btn_raw = 7'h40;
    ticks(6);
    chk("b7_press1", 32'(press_code), 32'd7);
    ticks(4);
    btn_raw = '0;
    ticks(6);
    chk("b7_rel_level", 32'(btn_level[6]), 32'd0);
    chk("b7_rel_press", 32'(btn_press), 32'h0);
    ticks(4);
    btn_raw = 7'h40;
    ticks(6);
    chk("b7_press2", 32'(btn_press), 32'h40);
    chk("b7_code2",  32'(press_code), 32'd7);

    // reset while btn1 is mid-count
    btn_raw = '0;
    ticks(10);
    btn_raw = 7'h01;
    ticks(4);
    reset = 1'b1;
    ticks(2);
    chk("mid_rst_level", 32'(btn_level), 32'h0);
    reset = 1'b0;
    ticks(5);
    chk("mid_early", 32'(btn_press), 32'h0);
    tick();
    chk("mid_press", 32'(btn_press), 32'h01);
    chk("mid_code",  32'(press_code), 32'd1);

    // random phase
    for (int it = 0; it < 4000; it++) begin
      if ($urandom_range(0, 99) < 12) btn_raw[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
